// File: rtl/uart_rx_os_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states, parity codes, vote helper.
package uart_rx_os_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_sampler.sv
// Line front end: 2-flop synchronizer, start-edge detect, bit-period counter and
// 2-of-3 vote around mid-bit.
module uart_rx_os_sampler
  import uart_rx_os_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic idle,
  output logic start_edge,
  output logic bit_tick,
  output logic bit_val
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;

  logic          rx_m;
  logic          rx_s;
  logic          rx_d;
  logic [CW-1:0] cnt;
  logic          s_a;
  logic          s_b;

  // The edge cycle itself counts as position 0 of the start bit, so the count restarts at 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
      cnt  <= '0;
      s_a  <= 1'b1;
      s_b  <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
      if (start_edge)
        cnt <= CW'(1);
      else if (idle)
        cnt <= '0;
      else if (cnt == CW'(CLKS_PER_BIT - 1))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (cnt == CW'(MID - 1)) s_a <= rx_s;
      if (cnt == CW'(MID))     s_b <= rx_s;
    end
  end

  assign start_edge = idle & rx_d & ~rx_s;
  assign bit_tick   = ~idle & (cnt == CW'(MID + 1));
  assign bit_val    = maj3(s_a, s_b, rx_s);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: frame FSM and valid/ready output register with overrun detect.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  rx_state_t            state;
  rx_state_t            state_next;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_bit;
  logic                 frame_done;
  logic                 par_err_now;
  logic                 start_edge;
  logic                 bit_tick;
  logic                 bit_val;

  uart_rx_os_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .idle       (state == ST_IDLE),
    .start_edge (start_edge),
    .bit_tick   (bit_tick),
    .bit_val    (bit_val)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      data_sr <= '0;
      par_bit <= 1'b0;
    end else begin
      state <= state_next;
      if (start_edge) bit_idx <= '0;
      if (bit_tick && state == ST_DATA) begin
        data_sr <= {bit_val, data_sr[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (bit_tick && state == ST_PARITY) par_bit <= bit_val;
    end
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      ST_IDLE:   if (start_edge) state_next = ST_START;
      ST_START:  if (bit_tick) state_next = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (bit_tick && bit_idx == 3'(DATA_BITS - 1))
          state_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (bit_tick) state_next = ST_STOP;
      ST_STOP:
        if (bit_tick) begin
          frame_done = 1'b1;
          state_next = ST_IDLE;
        end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    par_err_now = 1'b0;
    if (PARITY == PARITY_EVEN)
      par_err_now = par_bit ^ (^data_sr);
    else if (PARITY == PARITY_ODD)
      par_err_now = ~(par_bit ^ (^data_sr));
  end

  // A completing frame is dropped only if the held one is still undelivered this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data    <= data_sr;
          frame_err  <= ~bit_val;
          parity_err <= par_err_now;
          rx_valid   <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: vector table, hand-written corner cases and
// randomized back-to-back frames (incl. clock skew) against a queue-based reference.
`timescale 1ns/1ps
module tb_uart_rx_os;

  logic clk = 1'b0;
  real  half_ns = 5.0;
  always #(half_ns) clk = ~clk;

  logic       rst, rx, rx_p, rx_ready, rdy_p;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, frame_err, parity_err, overrun;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p;

  uart_rx_os #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun));

  uart_rx_os #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1)) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_ready(rdy_p), .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p));

  typedef struct { logic [7:0] data; logic fe; logic pe; } rec_t;
  typedef struct { bit sel; logic [7:0] d; bit flip; bit stop_v;
                   logic [7:0] ed; bit efe; bit epe; } vec_t;

  rec_t got_q[$], got_p_q[$], exp_q[$];
  int   ovr0 = 0, ovr_p = 0;
  int   n_chk = 0, n_fail = 0;
  real  bit_ns = 160.0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready)  got_q.push_back('{rx_data, frame_err, parity_err});
    if (rx_valid_p && rdy_p)   got_p_q.push_back('{rx_data_p, frame_err_p, parity_err_p});
    if (overrun === 1'b1)   ovr0++;
    if (overrun_p === 1'b1) ovr_p++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_line(input bit sel, input logic v);
    if (sel) rx_p = v; else rx = v;
  endtask

  task automatic align();
    @(negedge clk);
    #0.001;
  endtask

  // Transmitter model: start, 8 data LSB first, optional even parity (optionally inverted), stop.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input bit flip_par, input logic stop_v);
    drive_line(sel, 1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      drive_line(sel, d[i]);
      #(bit_ns);
    end
    if (with_par) begin
      drive_line(sel, (^d) ^ flip_par);
      #(bit_ns);
    end
    drive_line(sel, stop_v);
    #(bit_ns);
  endtask

  task automatic expect_frame(input bit sel, input logic [7:0] ed, input bit efe,
                              input bit epe, input string name);
    rec_t r;
    for (int i = 0; i < 300 && (sel ? got_p_q.size() : got_q.size()) == 0; i++)
      @(negedge clk);
    if ((sel ? got_p_q.size() : got_q.size()) == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no frame delivered within 300 cycles, expected %0h", name, ed);
    end else begin
      r = sel ? got_p_q.pop_front() : got_q.pop_front();
      chk(name, {r.data, r.fe, r.pe}, {ed, efe, epe});
      chk({name, "_single"}, sel ? got_p_q.size() : got_q.size(), 0);
    end
  endtask

  vec_t vt[8];

  initial begin
    rec_t r;
    logic [7:0] d;
    bit         fl;
    int         ov;
    real        skew[2];

    rst = 1'b0; rx = 1'b1; rx_p = 1'b1; rx_ready = 1'b1; rdy_p = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_outputs", {rx_data, rx_valid, frame_err, parity_err, overrun}, 12'h000);
    chk("reset_outputs_p", {rx_data_p, rx_valid_p, frame_err_p, parity_err_p, overrun_p}, 12'h000);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    vt[0] = '{0, 8'h15, 0, 1, 8'h15, 0, 0};
    vt[1] = '{0, 8'h4d, 0, 1, 8'h4d, 0, 0};
    vt[2] = '{0, 8'h03, 0, 1, 8'h03, 0, 0};
    vt[3] = '{0, 8'ha4, 0, 1, 8'ha4, 0, 0};
    vt[4] = '{1, 8'ha4, 1, 1, 8'ha4, 0, 1};
    vt[5] = '{1, 8'ha4, 0, 1, 8'ha4, 0, 0};
    vt[6] = '{0, 8'hc8, 0, 0, 8'hc8, 1, 0};
    vt[7] = '{0, 8'hfa, 0, 1, 8'hfa, 0, 0};

    for (int i = 0; i < 8; i++) begin
      align();
      send_frame(vt[i].sel, vt[i].d, vt[i].sel, vt[i].flip, vt[i].stop_v);
      drive_line(vt[i].sel, 1'b1);
      #(2 * bit_ns);
      expect_frame(vt[i].sel, vt[i].ed, vt[i].efe, vt[i].epe, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_valid_low", i), vt[i].sel ? rx_valid_p : rx_valid, 0);
    end

    // False start: three cycles of low is rejected by the mid-bit vote.
    align();
    rx = 1'b0;
    #30;
    rx = 1'b1;
    #(2 * bit_ns);
    chk("false_start_quiet", got_q.size(), 0);
    align();
    send_frame(0, 8'h22, 0, 0, 1'b1);
    #(2 * bit_ns);
    expect_frame(0, 8'h22, 0, 0, "after_false_start");

    // Overrun: consumer stalled across two frames.
    @(posedge clk); #2;
    rx_ready = 1'b0;
    ov = ovr0;
    align();
    send_frame(0, 8'h14, 0, 0, 1'b1);
    #(bit_ns);
    chk("stall_first_no_overrun", ovr0 - ov, 0);
    chk("stall_first_held", {rx_valid, rx_data}, {1'b1, 8'h14});
    align();
    send_frame(0, 8'h32, 0, 0, 1'b1);
    #(bit_ns);
    chk("overrun_pulse_count", ovr0 - ov, 1);
    chk("overrun_data_held", {rx_valid, rx_data, frame_err, parity_err}, {1'b1, 8'h14, 2'b00});
    @(posedge clk); #2;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    expect_frame(0, 8'h14, 0, 0, "overrun_release");
    chk("overrun_valid_drop", rx_valid, 0);

    // Reset asserted in the middle of data bit 4, released in data bit 5 (a 1).
    align();
    fork
      send_frame(0, 8'hea, 0, 0, 1'b1);
      begin
        #(bit_ns * 5 + 80);
        rst = 1'b0;
        #(bit_ns);
        rst = 1'b1;
      end
    join
    #(2 * bit_ns);
    chk("reset_abort_none", got_q.size(), 0);
    chk("reset_abort_outputs", {rx_data, rx_valid, frame_err, parity_err}, 11'h000);
    align();
    send_frame(0, 8'hea, 0, 0, 1'b1);
    #(2 * bit_ns);
    expect_frame(0, 8'hea, 0, 0, "after_reset");

    // Randomized even-parity frames, back to back; error iff total ones in data+parity is odd.
    exp_q.delete();
    align();
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom);
      fl = ($urandom_range(0, 3) == 0);
      exp_q.push_back('{d, 1'b0, ^{d, (^d) ^ fl}});
      send_frame(1, d, 1, fl, 1'b1);
    end
    rx_p = 1'b1;
    #(2 * bit_ns);
    chk("rand_parity_count", got_p_q.size(), 12);
    while (exp_q.size() > 0 && got_p_q.size() > 0) begin
      r = got_p_q.pop_front();
      chk("rand_parity_frame", {r.data, r.fe, r.pe},
          {exp_q[0].data, exp_q[0].fe, exp_q[0].pe});
      void'(exp_q.pop_front());
    end
    chk("rand_parity_overrun", ovr_p, 0);

    // Receiver clock +/-3% against a 10 ns transmitter, 11 back-to-back frames each.
    skew[0] = 5.15;
    skew[1] = 4.85;
    for (int s = 0; s < 2; s++) begin
      half_ns = skew[s];
      repeat (10) @(negedge clk);
      exp_q.delete();
      got_q.delete();
      align();
      for (int i = 0; i < 11; i++) begin
        d = 8'($urandom);
        exp_q.push_back('{d, 1'b0, 1'b0});
        send_frame(0, d, 0, 0, 1'b1);
      end
      rx = 1'b1;
      #(2 * bit_ns);
      chk($sformatf("skew%0d_count", s), got_q.size(), 11);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        r = got_q.pop_front();
        chk($sformatf("skew%0d_frame", s), {r.data, r.fe, r.pe},
            {exp_q[0].data, exp_q[0].fe, exp_q[0].pe});
        void'(exp_q.pop_front());
      end
    end
    half_ns = 5.0;
    chk("skew_no_overrun", ovr0 - ov, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
